// File: rtl/raster_pkg.sv
// Shared types and helpers for the raster coordinate tracker: skid buffer state
// encoding, coordinate width functions and default frame geometry.
package raster_pkg;

  localparam int DEFAULT_WIDTH  = 1080;
  localparam int DEFAULT_HEIGHT = 960;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

  function automatic int x_coord_w(input int width);
    return $clog2(width) + 1;
  endfunction

  function automatic int y_coord_w(input int height);
    return $clog2(height) + 1;
  endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry AXI-Stream skid buffer: main output register plus one skid register,
// registered ready, and a one-cycle out_fresh flag when the main register is reloaded.
module axis_skid_buf
  import raster_pkg::*;
#(
  parameter int PAYLOAD_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_fresh
);

  skid_state_e          state_q, state_d;
  logic [PAYLOAD_W-1:0] main_q, main_d;
  logic [PAYLOAD_W-1:0] skid_q, skid_d;
  logic                 ready_q, ready_d;
  logic                 fresh_q, fresh_d;
  logic                 accept, xfer;

  assign accept = in_valid && ready_q;
  assign xfer   = (state_q != SKID_EMPTY) && out_ready;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    fresh_d = 1'b0;
    unique case (state_q)
      SKID_EMPTY: if (accept) begin
        main_d  = in_payload;
        fresh_d = 1'b1;
        state_d = SKID_ONE;
      end
      SKID_ONE: begin
        if (accept && xfer) begin
          main_d  = in_payload;
          fresh_d = 1'b1;
        end else if (accept) begin
          skid_d  = in_payload;
          state_d = SKID_FULL;
        end else if (xfer) begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_FULL: if (xfer) begin
        main_d  = skid_q;
        fresh_d = 1'b1;
        state_d = SKID_ONE;
      end
      default: state_d = SKID_EMPTY;
    endcase
    ready_d = (state_d != SKID_FULL);
  end

  // NOTE: state uses non-blocking assignments so all flops update from pre-edge values.
  // NOTE: the data registers are reset too, because the output payload must read 0 out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SKID_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b0;
      fresh_q <= 1'b0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= ready_d;
      fresh_q <= fresh_d;
    end
  end

  assign in_ready    = ready_q;
  assign out_valid   = (state_q != SKID_EMPTY);
  assign out_payload = main_q;
  assign out_fresh   = fresh_q;

endmodule

// File: rtl/raster_coord_tracker.sv
// Tags each AXI-Stream pixel beat with its raster (X,Y), regenerating SOF/EOL.
// Define RASTER_SYNC_CHECK_EN to resynchronise on source tuser/tlast and flag mismatches.
module raster_coord_tracker
  import raster_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int HEIGHT = DEFAULT_HEIGHT,
  parameter int PPC    = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [DATA_W*PPC-1:0]          AXIS_IN_tdata,
  input  logic                           AXIS_IN_tvalid,
  output logic                           AXIS_IN_tready,
  input  logic                           AXIS_IN_tuser,
  input  logic                           AXIS_IN_tlast,
  output logic [DATA_W*PPC-1:0]          AXIS_OUT_tdata,
  output logic                           AXIS_OUT_tvalid,
  input  logic                           AXIS_OUT_tready,
  output logic                           AXIS_OUT_tuser,
  output logic                           AXIS_OUT_tlast,
  output logic [x_coord_w(WIDTH)-1:0]    OutX,
  output logic [y_coord_w(HEIGHT)-1:0]   OutY,
  output logic                           Frame_Done,
  output logic                           Sync_Err
);

  localparam int XW     = x_coord_w(WIDTH);
  localparam int YW     = y_coord_w(HEIGHT);
  localparam int BEAT_W = DATA_W * PPC;
  localparam int PW     = BEAT_W + XW + YW + 3;

  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - PPC);
  localparam logic [XW-1:0] X_STEP = XW'(PPC);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

  logic [XW-1:0] x_q, x_d, beat_x;
  logic [YW-1:0] y_q, y_d, beat_y;
  logic          beat_eol, beat_sof, beat_err;
  logic          sof_mismatch, eol_mismatch;
  logic          accept, out_fresh;
  logic [PW-1:0] in_payload, out_payload;

  assign accept = AXIS_IN_tvalid && AXIS_IN_tready;

`ifdef RASTER_SYNC_CHECK_EN
  assign sof_mismatch = AXIS_IN_tuser && (x_q != '0 || y_q != '0);
  assign eol_mismatch = AXIS_IN_tlast && (x_q != X_LAST);
`else
  logic unused_sync;
  assign sof_mismatch = 1'b0;
  assign eol_mismatch = 1'b0;
  assign unused_sync  = AXIS_IN_tuser ^ AXIS_IN_tlast;
`endif

  // A source SOF mismatch takes precedence: the beat restarts the frame and its tlast is not judged.
  always_comb begin
    beat_x   = x_q;
    beat_y   = y_q;
    beat_err = sof_mismatch || eol_mismatch;
    if (sof_mismatch) begin
      beat_x = '0;
      beat_y = '0;
    end
    beat_eol = (beat_x == X_LAST) || (!sof_mismatch && eol_mismatch);
    beat_sof = (beat_x == '0) && (beat_y == '0);

    x_d = x_q;
    y_d = y_q;
    if (accept) begin
      if (beat_eol) begin
        x_d = '0;
        y_d = (beat_y == Y_LAST) ? '0 : beat_y + YW'(1);
      end else begin
        x_d = beat_x + X_STEP;
        y_d = beat_y;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign in_payload = {beat_err, beat_sof, beat_eol, beat_y, beat_x, AXIS_IN_tdata};

  axis_skid_buf #(
    .PAYLOAD_W(PW)
  ) u_skid (
    .clk        (clk),
    .reset      (reset),
    .in_payload (in_payload),
    .in_valid   (AXIS_IN_tvalid),
    .in_ready   (AXIS_IN_tready),
    .out_payload(out_payload),
    .out_valid  (AXIS_OUT_tvalid),
    .out_ready  (AXIS_OUT_tready),
    .out_fresh  (out_fresh)
  );

  assign AXIS_OUT_tdata = out_payload[BEAT_W-1:0];
  assign OutX           = out_payload[BEAT_W +: XW];
  assign OutY           = out_payload[BEAT_W+XW +: YW];
  assign AXIS_OUT_tlast = out_payload[PW-3];
  assign AXIS_OUT_tuser = out_payload[PW-2];
  assign Sync_Err       = out_fresh && out_payload[PW-1];
  assign Frame_Done     = AXIS_OUT_tvalid && AXIS_OUT_tready && (OutX == X_LAST) && (OutY == Y_LAST);

endmodule

// File: tb/tb_raster_coord_tracker.sv
// Self-checking bench: stall vector table, hand-written corner sequences, and
// randomized handshakes scored against a queue-based raster model.
module tb_raster_coord_tracker;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int W4 = 8;
  localparam int H4 = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0, in_user = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic        ir, ov, ou, ol, fd, se;
  logic [15:0] od;
  logic [3:0]  ox;
  logic [2:0]  oy;

  logic [31:0] in_data4 = '0;
  logic        in_valid4 = 1'b0, out_ready4 = 1'b0;
  logic        ir4, ov4, ou4, ol4, fd4, se4;
  logic [31:0] od4;
  logic [3:0]  ox4;
  logic [1:0]  oy4;

  always #5 clk = ~clk;

  raster_coord_tracker #(.DATA_W(16), .WIDTH(W), .HEIGHT(H), .PPC(1)) dut (
    .clk(clk), .reset(reset),
    .AXIS_IN_tdata(in_data), .AXIS_IN_tvalid(in_valid), .AXIS_IN_tready(ir),
    .AXIS_IN_tuser(in_user), .AXIS_IN_tlast(in_last),
    .AXIS_OUT_tdata(od), .AXIS_OUT_tvalid(ov), .AXIS_OUT_tready(out_ready),
    .AXIS_OUT_tuser(ou), .AXIS_OUT_tlast(ol),
    .OutX(ox), .OutY(oy), .Frame_Done(fd), .Sync_Err(se)
  );

  raster_coord_tracker #(.DATA_W(8), .WIDTH(W4), .HEIGHT(H4), .PPC(4)) dut4 (
    .clk(clk), .reset(reset),
    .AXIS_IN_tdata(in_data4), .AXIS_IN_tvalid(in_valid4), .AXIS_IN_tready(ir4),
    .AXIS_IN_tuser(1'b0), .AXIS_IN_tlast(1'b0),
    .AXIS_OUT_tdata(od4), .AXIS_OUT_tvalid(ov4), .AXIS_OUT_tready(out_ready4),
    .AXIS_OUT_tuser(ou4), .AXIS_OUT_tlast(ol4),
    .OutX(ox4), .OutY(oy4), .Frame_Done(fd4), .Sync_Err(se4)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the n-th accepted beat of a frame sits at raster position n.
  typedef struct {
    logic [15:0] data;
    int          x;
    int          y;
    bit          user;
    bit          last;
  } exp_beat_t;

  exp_beat_t q[$];
  int        n_acc;
  int        cnt_user, cnt_last, cnt_fd;

  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_user   = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    q.delete();
    n_acc = 0;
    @(negedge clk);
    check("rst_out_valid", ov, 0);
    check("rst_in_ready", ir, 0);
    check("rst_tdata", od, 0);
    check("rst_outx", ox, 0);
    check("rst_outy", oy, 0);
    check("rst_tuser", ou, 0);
    check("rst_tlast", ol, 0);
    check("rst_frame_done", fd, 0);
    check("rst_sync_err", se, 0);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // One clock of the main DUT against the model, called and returning at a negedge.
  task automatic cyc(input bit iv, input bit ordy);
    exp_beat_t nb;
    bit        exp_fd;
    check("out_valid", ov, (q.size() > 0) ? 1 : 0);
    check("in_ready", ir, (q.size() < 2) ? 1 : 0);
    if (q.size() > 0) begin
      check("tdata", od, q[0].data);
      check("outx", ox, q[0].x);
      check("outy", oy, q[0].y);
      check("tuser", ou, q[0].user);
      check("tlast", ol, q[0].last);
    end
    check("sync_err", se, 0);
    nb.x    = n_acc % W;
    nb.y    = (n_acc / W) % H;
    nb.user = (nb.x == 0) && (nb.y == 0);
    nb.last = (nb.x == W - 1);
    nb.data = 16'($urandom);
    in_data   = nb.data;
    in_valid  = iv;
    in_user   = nb.user;
    in_last   = nb.last;
    out_ready = ordy;
    #1;
    exp_fd = 1'b0;
    if (ordy && q.size() > 0) exp_fd = (q[0].x == W - 1) && (q[0].y == H - 1);
    check("frame_done", fd, exp_fd);
    if (fd) cnt_fd++;
    if (ordy && q.size() > 0) begin
      if (q[0].user) cnt_user++;
      if (q[0].last) cnt_last++;
      void'(q.pop_front());
    end
    if (iv && ir) begin
      q.push_back(nb);
      n_acc++;
    end
    @(negedge clk);
  endtask

  // Steady-stream beat with explicit source sync flags and hand-derived expectations.
  task automatic beat_hs(input bit tu, input bit tl, input int ex, input int ey,
                         input bit eu, input bit el, input bit ee);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_user   = tu;
    in_last   = tl;
    in_data   = 16'($urandom);
    @(negedge clk);
    check("hs_valid", ov, 1);
    check("hs_outx", ox, ex);
    check("hs_outy", oy, ey);
    check("hs_tuser", ou, eu);
    check("hs_tlast", ol, el);
    check("hs_sync_err", se, ee);
  endtask

  typedef struct {
    bit          iv;
    bit          ordy;
    logic [15:0] din;
    bit          exp_ov;
    bit          exp_ir;
    int          exp_x;
    logic [15:0] exp_data;
  } vec_t;

  vec_t tab[10];

  initial begin
    tab[0] = '{1'b1, 1'b0, 16'hA000, 1'b1, 1'b1, 0, 16'hA000};
    tab[1] = '{1'b1, 1'b0, 16'hA001, 1'b1, 1'b0, 0, 16'hA000};
    tab[2] = '{1'b1, 1'b0, 16'hA002, 1'b1, 1'b0, 0, 16'hA000};
    tab[3] = '{1'b1, 1'b0, 16'hA003, 1'b1, 1'b0, 0, 16'hA000};
    tab[4] = '{1'b1, 1'b1, 16'hA004, 1'b1, 1'b1, 1, 16'hA001};
    tab[5] = '{1'b1, 1'b1, 16'hA005, 1'b1, 1'b1, 2, 16'hA005};
    tab[6] = '{1'b0, 1'b1, 16'hA006, 1'b0, 1'b1, 0, 16'h0000};
    tab[7] = '{1'b1, 1'b1, 16'hA007, 1'b1, 1'b1, 3, 16'hA007};
    tab[8] = '{1'b0, 1'b0, 16'hA008, 1'b1, 1'b1, 3, 16'hA007};
    tab[9] = '{1'b0, 1'b1, 16'hA009, 1'b0, 1'b1, 0, 16'h0000};

    do_reset();

    // Four pixels per beat: X alternates 0,4 and every second beat ends a line.
    in_valid4  = 1'b1;
    out_ready4 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_data4 = 32'h1000 + 32'(k);
      @(negedge clk);
      check("p4_valid", ov4, 1);
      check("p4_data", od4, 32'h1000 + 32'(k));
      check("p4_outx", ox4, (k % 2) * 4);
      check("p4_outy", oy4, (k / 2) % H4);
      check("p4_tuser", ou4, (k % 4) == 0);
      check("p4_tlast", ol4, (k % 2) == 1);
      check("p4_frame_done", fd4, (k == 3) || (k == 7));
      check("p4_sync_err", se4, 0);
    end
    in_valid4 = 1'b0;

    // Output stall fills the skid register; nothing is lost or repeated.
    for (int i = 0; i < 10; i++) begin
      in_valid  = tab[i].iv;
      out_ready = tab[i].ordy;
      in_data   = tab[i].din;
      in_user   = (i == 0);
      in_last   = 1'b0;
      @(negedge clk);
      check("vec_out_valid", ov, tab[i].exp_ov);
      check("vec_in_ready", ir, tab[i].exp_ir);
      if (tab[i].exp_ov) begin
        check("vec_outx", ox, tab[i].exp_x);
        check("vec_outy", oy, 0);
        check("vec_tdata", od, tab[i].exp_data);
      end
    end

    // One full 8x4 frame at full throughput.
    do_reset();
    cnt_user = 0;
    cnt_last = 0;
    cnt_fd   = 0;
    for (int i = 0; i < 33; i++) cyc(1'b1, 1'b1);
    check("frame_tuser_count", cnt_user, 1);
    check("frame_tlast_count", cnt_last, 4);
    check("frame_done_count", cnt_fd, 1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1);

    // Source SOF on beat 5, then a premature EOL at X=3.
    do_reset();
    for (int k = 0; k < 5; k++) beat_hs(k == 0, 1'b0, k, 0, k == 0, 1'b0, 1'b0);
`ifdef RASTER_SYNC_CHECK_EN
    beat_hs(1'b1, 1'b0, 0, 0, 1'b1, 1'b0, 1'b1);
    beat_hs(1'b0, 1'b0, 1, 0, 1'b0, 1'b0, 1'b0);
    beat_hs(1'b0, 1'b0, 2, 0, 1'b0, 1'b0, 1'b0);
    beat_hs(1'b0, 1'b1, 3, 0, 1'b0, 1'b1, 1'b1);
    beat_hs(1'b0, 1'b0, 0, 1, 1'b0, 1'b0, 1'b0);
`else
    beat_hs(1'b1, 1'b0, 5, 0, 1'b0, 1'b0, 1'b0);
    beat_hs(1'b0, 1'b0, 6, 0, 1'b0, 1'b0, 1'b0);
    beat_hs(1'b0, 1'b0, 7, 0, 1'b0, 1'b1, 1'b0);
    beat_hs(1'b0, 1'b1, 0, 1, 1'b0, 1'b0, 1'b0);
    beat_hs(1'b0, 1'b0, 1, 1, 1'b0, 1'b0, 1'b0);
`endif
    in_valid = 1'b0;

    // Reset while FULL at beat 13 discards held beats; the next frame restarts at (0,0).
    do_reset();
    for (int i = 0; i < 13; i++) cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    check("full_before_reset", q.size(), 2);
    check("full_in_ready", ir, 0);
    #2 reset = 1'b1;
    #1;
    check("async_rst_out_valid", ov, 0);
    check("async_rst_in_ready", ir, 0);
    do_reset();
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1);

    // Random handshakes over several frames.
    for (int i = 0; i < 800; i++) cyc($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1);
    check("drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/raster_coord_tracker.md
RASTER_COORD_TRACKER -- requirements
Module: raster_coord_tracker

Interface
REQ-001 SHALL have parameter DATA_W, default 16, bits per pixel.
REQ-002 SHALL have parameter WIDTH, default 1080, pixels per line; WIDTH SHALL be a multiple of PPC.
REQ-003 SHALL have parameter HEIGHT, default 960, lines per frame.
REQ-004 SHALL have parameter PPC, default 1, pixels per beat (1, 2 or 4).
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 reset  in  1  asynchronous, active-high.
REQ-007 AXIS_IN_tdata  in  DATA_W*PPC  pixel beat, pixel 0 in LSBs.
REQ-008 AXIS_IN_tvalid / AXIS_IN_tready  in / out  1 each  input handshake.
REQ-009 AXIS_IN_tuser / AXIS_IN_tlast  in  1 each  source start-of-frame / end-of-line.
REQ-010 AXIS_OUT_tdata  out  DATA_W*PPC  forwarded pixel beat.
REQ-011 AXIS_OUT_tvalid / AXIS_OUT_tready  out / in  1 each  output handshake.
REQ-012 AXIS_OUT_tuser / AXIS_OUT_tlast  out  1 each  regenerated SOF / EOL.
REQ-013 OutX  out  $clog2(WIDTH)+1  X of first pixel in current output beat.
REQ-014 OutY  out  $clog2(HEIGHT)+1  Y of current output beat.
REQ-015 Frame_Done  out  1  one-cycle pulse on output handshake of the frame's final beat.
REQ-016 Sync_Err  out  1  one-cycle pulse on sync mismatch (see Configuration).

Function
REQ-017 Input beat SHALL be accepted when AXIS_IN_tvalid && AXIS_IN_tready; output beat transferred when AXIS_OUT_tvalid && AXIS_OUT_tready.
REQ-018 Datapath SHALL be a main output register plus one skid register; states EMPTY (nothing held), ONE (main valid), FULL (main+skid valid).
REQ-019 Transitions: EMPTY-accept->ONE; ONE-accept-only->FULL; ONE-transfer-only->EMPTY; ONE-accept+transfer->ONE; FULL-transfer->ONE (skid moves to main).
REQ-020 AXIS_IN_tready SHALL be a registered signal, 1 in EMPTY/ONE, 0 in FULL.
REQ-021 Latency SHALL be one cycle from input acceptance to AXIS_OUT_tvalid in EMPTY.
REQ-022 AXIS_OUT_tdata, tuser, tlast, OutX, OutY SHALL be held stable while AXIS_OUT_tvalid && !AXIS_OUT_tready.
REQ-023 Coordinate counters SHALL advance only on input acceptance; X steps by PPC.
REQ-024 When X == WIDTH-PPC on acceptance, X SHALL wrap to 0 and Y increment; when Y == HEIGHT-1 too, Y SHALL wrap to 0.
REQ-025 Coordinates SHALL be captured with the beat and travel with it through skid.
REQ-026 AXIS_OUT_tuser SHALL be 1 iff beat coordinates are (0,0); AXIS_OUT_tlast SHALL be 1 iff X == WIDTH-PPC.
REQ-027 Frame_Done SHALL pulse on transfer of beat (WIDTH-PPC, HEIGHT-1); Sync_Err and Frame_Done SHALL otherwise be 0.

Reset
REQ-028 On reset: state EMPTY, AXIS_IN_tready=0, AXIS_OUT_tvalid=0, tdata/tuser/tlast=0, OutX=OutY=0, counters=0, Frame_Done=0, Sync_Err=0.
REQ-029 AXIS_IN_tready SHALL rise on the first clk edge after reset deassertion; reset mid-frame SHALL discard held beats and restart at (0,0).

Configuration
REQ-030 With RASTER_SYNC_CHECK_EN defined: accepted AXIS_IN_tuser=1 at counter != (0,0) SHALL pulse Sync_Err and tag the beat (0,0), counting on from there.
REQ-031 With RASTER_SYNC_CHECK_EN defined: accepted AXIS_IN_tlast=1 with X != WIDTH-PPC SHALL pulse Sync_Err, tag the beat as end of line, next beat X=0, Y+1.
REQ-032 Sync_Err SHALL pulse in the cycle the offending beat reaches the output register; tuser wins when both mismatch.
REQ-033 Without RASTER_SYNC_CHECK_EN: AXIS_IN_tuser/tlast SHALL be ignored and Sync_Err tied 0.

Structure
REQ-034 Shared package raster_pkg SHALL hold skid state enum, coordinate-width functions and default WIDTH/HEIGHT constants.
REQ-035 Skid buffer SHALL be sub-module axis_skid_buf (parametrised payload width); counters and sync check in top level.

Verification
REQ-036 WIDTH=8, HEIGHT=4, PPC=1, tready=1 steady: 32 beats -> OutX 0..7 wraps, OutY 0..3, tlast every 8th, tuser on beat 0, Frame_Done on beat 31.
REQ-037 PPC=4, WIDTH=8: OutX alternates 0,4; tlast on every second beat.
REQ-038 Stall AXIS_OUT_tready=0 for 3 cycles with tvalid=1 input: state FULL, AXIS_IN_tready=0 after second beat, no beat lost or duplicated, outputs stable.
REQ-039 RASTER_SYNC_CHECK_EN, tuser=1 on beat 5: Sync_Err pulse once, that beat OutX=0 OutY=0, next OutX=1.
REQ-040 Reset asserted at beat 13 while FULL: AXIS_OUT_tvalid=0 immediately, next frame starts at (0,0) with tuser=1.
